sw_feeder: RTL and testbench

SW_FEEDER -- requirements
Module: sw_feeder

---
 rtl/sw_pkg.sv | 27 ++
 rtl/sw_base_buf.sv | 52 +++++
 rtl/sw_feeder.sv | 178 +++++++++++++++++
 tb/tb_sw_feeder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman base-stream feeder.
// Holds the 2-bit base encoding, default frame lengths, the FSM state type
// and a width helper used by the feeder and its base buffers.
package sw_pkg;

    localparam int unsigned BASE_W        = 2;
    localparam int unsigned LEN_REF_DEF   = 64;
    localparam int unsigned LEN_QUERY_DEF = 48;

    // 2-bit nucleotide encoding
    localparam logic [BASE_W-1:0] BASE_A = 2'b00;
    localparam logic [BASE_W-1:0] BASE_C = 2'b01;
    localparam logic [BASE_W-1:0] BASE_G = 2'b10;
    localparam logic [BASE_W-1:0] BASE_T = 2'b11;

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_WAIT_FIN = 2'd2
    } state_t;

    // Address width that never collapses to zero bits
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_base_buf.sv
// Byte-written, base-indexed sequence buffer.
// Ports:
//   clk      - clock
//   we       - write strobe for one packed byte (four bases)
//   waddr    - byte address to write
//   wdata    - four bases, bits[1:0] earliest
//   ridx     - base index to read
//   rbase_c  - combinational read of base ridx (write-through on same byte)
module sw_base_buf
    import sw_pkg::*;
#(
    parameter  int unsigned DEPTH  = LEN_REF_DEF,
    localparam int unsigned NBYTES = DEPTH / 4,
    localparam int unsigned AW     = clog2_min1(DEPTH / 4),
    localparam int unsigned IW     = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [7:0]        wdata,
    input  logic [IW-1:0]     ridx,
    output logic [BASE_W-1:0] rbase_c
);

    logic [7:0]    mem [NBYTES];
    logic [AW-1:0] rbyte_idx;
    logic [7:0]    rbyte;

    assign rbyte_idx = AW'(ridx >> 2);

    // Storage is not reset; contents are always rewritten before use
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Forward the byte being written so a freshly loaded base is readable at once
    always_comb begin
        rbyte = mem[rbyte_idx];
        if (we && (waddr == rbyte_idx)) begin
            rbyte = wdata;
        end
        case (ridx[1:0])
            2'd0:    rbase_c = rbyte[1:0];
            2'd1:    rbase_c = rbyte[3:2];
            2'd2:    rbase_c = rbyte[5:4];
            default: rbase_c = rbyte[7:6];
        endcase
    end

endmodule

// File: rtl/sw_feeder.sv
// Loads a packed reference and query sequence byte by byte, then streams
// them base by base to a Smith-Waterman aligner and waits for its finish.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   in_valid/in_ready - upstream byte handshake, in_data four packed bases
//   sw_valid          - base stream valid (registered)
//   sw_data_ref/query - reference / query base (registered, 0 when idle)
//   sw_finish         - completion pulse from the aligner (used in WAIT_FIN)
//   busy              - high while streaming or waiting for finish
module sw_feeder
    import sw_pkg::*;
#(
    parameter int unsigned LEN_REF   = LEN_REF_DEF,
    parameter int unsigned LEN_QUERY = LEN_QUERY_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              sw_valid,
    output logic [BASE_W-1:0] sw_data_ref,
    output logic [BASE_W-1:0] sw_data_query,
    input  logic              sw_finish,
    output logic              busy
);

    localparam int unsigned NRB    = LEN_REF / 4;
    localparam int unsigned NQB    = LEN_QUERY / 4;
    localparam int unsigned NB     = NRB + NQB;
    localparam int unsigned BCNT_W = $clog2(NB + 1);
    localparam int unsigned SCNT_W = $clog2(LEN_REF + 1);
    localparam int unsigned RAW    = clog2_min1(NRB);
    localparam int unsigned QAW    = clog2_min1(NQB);
    localparam int unsigned RIW    = clog2_min1(LEN_REF);
    localparam int unsigned QIW    = clog2_min1(LEN_QUERY);

    state_t              state, state_n;
    logic [BCNT_W-1:0]   bcnt;
    logic [SCNT_W-1:0]   scnt;
    logic                accept, last_byte, stream_more, query_live;
    logic                ref_we, qry_we;
    logic [RAW-1:0]      ref_waddr;
    logic [QAW-1:0]      qry_waddr;
    logic [RIW-1:0]      ref_ridx;
    logic [QIW-1:0]      qry_ridx;
    logic [BASE_W-1:0]   ref_base_c, qry_base_c;
    logic                sw_valid_d, in_ready_d, busy_d;
    logic [BASE_W-1:0]   sw_data_ref_d, sw_data_query_d;

    assign accept      = in_valid && in_ready && (state == ST_LOAD);
    assign last_byte   = (bcnt == BCNT_W'(NB - 1));
    assign stream_more = (scnt < SCNT_W'(LEN_REF));
    assign query_live  = (scnt < SCNT_W'(LEN_QUERY));

    // Byte routing: first NRB bytes to the reference, the rest to the query
    assign ref_we    = accept && (bcnt < BCNT_W'(NRB));
    assign qry_we    = accept && !(bcnt < BCNT_W'(NRB));
    assign ref_waddr = RAW'(bcnt);
    assign qry_waddr = QAW'(bcnt - BCNT_W'(NRB));

    // scnt is the index of the next base to present; base 0 is read while loading
    assign ref_ridx = (state == ST_STREAM) ? RIW'(scnt) : '0;
    assign qry_ridx = ((state == ST_STREAM) && query_live) ? QIW'(scnt) : '0;

    sw_base_buf #(.DEPTH(LEN_REF)) u_ref_buf (
        .clk     (clk),
        .we      (ref_we),
        .waddr   (ref_waddr),
        .wdata   (in_data),
        .ridx    (ref_ridx),
        .rbase_c (ref_base_c)
    );

    sw_base_buf #(.DEPTH(LEN_QUERY)) u_qry_buf (
        .clk     (clk),
        .we      (qry_we),
        .waddr   (qry_waddr),
        .wdata   (in_data),
        .ridx    (qry_ridx),
        .rbase_c (qry_base_c)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            ST_LOAD:     if (accept && last_byte) state_n = ST_STREAM;
            ST_STREAM:   if (!stream_more)        state_n = ST_WAIT_FIN;
            ST_WAIT_FIN: if (sw_finish)           state_n = ST_LOAD;
            default:                              state_n = ST_LOAD;
        endcase
    end

    // Output logic: values to be registered on the next edge
    always_comb begin
        sw_valid_d      = 1'b0;
        sw_data_ref_d   = BASE_A;
        sw_data_query_d = BASE_A;
        in_ready_d      = (state_n == ST_LOAD);
        busy_d          = (state_n != ST_LOAD);
        case (state)
            ST_LOAD: begin
                if (accept && last_byte) begin
                    sw_valid_d      = 1'b1;
                    sw_data_ref_d   = ref_base_c;
                    sw_data_query_d = qry_base_c;
                end
            end
            ST_STREAM: begin
                if (stream_more) begin
                    sw_valid_d      = 1'b1;
                    sw_data_ref_d   = ref_base_c;
                    sw_data_query_d = query_live ? qry_base_c : BASE_A;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_valid      <= 1'b0;
            sw_data_ref   <= BASE_A;
            sw_data_query <= BASE_A;
            in_ready      <= 1'b1;
            busy          <= 1'b0;
        end else begin
            sw_valid      <= sw_valid_d;
            sw_data_ref   <= sw_data_ref_d;
            sw_data_query <= sw_data_query_d;
            in_ready      <= in_ready_d;
            busy          <= busy_d;
        end
    end

    // Byte and stream counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt <= '0;
            scnt <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        bcnt <= bcnt + BCNT_W'(1);
                        if (last_byte) begin
                            scnt <= SCNT_W'(1);
                        end
                    end
                end
                ST_STREAM: begin
                    if (stream_more) begin
                        scnt <= scnt + SCNT_W'(1);
                    end
                end
                ST_WAIT_FIN: begin
                    if (sw_finish) begin
                        bcnt <= '0;
                        scnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_feeder.sv
// Directed bench for sw_feeder: back-to-back and gapped loads, held in_valid
// while busy, ignored finish during streaming, and reset mid-load/mid-stream.
module tb_sw_feeder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       sw_valid;
    logic [1:0] sw_data_ref;
    logic [1:0] sw_data_query;
    logic       sw_finish;
    logic       busy;

    int n_checks;
    int n_errors;

    sw_feeder #(.LEN_REF(64), .LEN_QUERY(48)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .sw_valid      (sw_valid),
        .sw_data_ref   (sw_data_ref),
        .sw_data_query (sw_data_query),
        .sw_finish     (sw_finish),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer nbytes bytes starting at frame byte index 'start'; returns at the
    // negedge where the last byte is driven (its accepting edge is next).
    task automatic load_frame(input logic [7:0] rb, input logic [7:0] qb,
                              input bit gap, input int start, input int nbytes);
        int acc   = 0;
        int cyc   = 0;
        bit tog   = 1'b0;
        bit early = 1'b0;
        while (acc < nbytes && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (sw_valid) early = 1'b1;
            tog      = ~tog;
            in_valid = gap ? tog : 1'b1;
            in_data  = ((start + acc) < 16) ? rb : qb;
            if (in_valid && in_ready) acc++;
        end
        check("load_bytes", 32'(acc), 32'(nbytes));
        check("load_no_early_valid", 32'(early), 32'd0);
    endtask

    // Check all 64 stream cycles; in_valid held to 'hold' and sw_finish
    // pulsed in cycle fin_at (negative = never).
    task automatic stream_check(input logic [7:0] rb, input logic [7:0] qb,
                                input bit hold, input int fin_at);
        logic [1:0] exp_r, exp_q;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            in_valid  = hold;
            in_data   = 8'h55;
            sw_finish = (c == fin_at);
            exp_r = 2'((rb >> (2 * (c % 4))) & 8'h3);
            exp_q = (c < 48) ? 2'((qb >> (2 * (c % 4))) & 8'h3) : 2'b00;
            check($sformatf("stream_valid c=%0d", c), 32'(sw_valid), 32'd1);
            check($sformatf("stream_ref c=%0d", c), 32'(sw_data_ref), 32'(exp_r));
            check($sformatf("stream_query c=%0d", c), 32'(sw_data_query), 32'(exp_q));
            check($sformatf("stream_in_ready c=%0d", c), 32'(in_ready), 32'd0);
            check($sformatf("stream_busy c=%0d", c), 32'(busy), 32'd1);
        end
    endtask

    // Idle in WAIT_FIN for n cycles, then pulse sw_finish and expect LOAD.
    task automatic wait_and_finish(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sw_finish = 1'b0;
            check($sformatf("wait_valid i=%0d", i), 32'(sw_valid), 32'd0);
            check($sformatf("wait_data i=%0d", i), 32'({sw_data_ref, sw_data_query}), 32'd0);
            check($sformatf("wait_busy i=%0d", i), 32'(busy), 32'd1);
            check($sformatf("wait_in_ready i=%0d", i), 32'(in_ready), 32'd0);
        end
        sw_finish = 1'b1;
        @(negedge clk);
        sw_finish = 1'b0;
        in_valid  = 1'b0;
        check("fin_in_ready", 32'(in_ready), 32'd1);
        check("fin_busy", 32'(busy), 32'd0);
        check("fin_valid", 32'(sw_valid), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        sw_finish = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(sw_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'({sw_data_ref, sw_data_query}), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(sw_valid), 32'd0);

        // Frame 1: back-to-back, in_valid held through STREAM and WAIT_FIN
        load_frame(8'hE4, 8'h1B, 1'b0, 0, 28);
        stream_check(8'hE4, 8'h1B, 1'b1, -1);
        wait_and_finish(5);

        // Frame 2: ref all 0, query all 3; finish pulse in cycle 10 is ignored
        load_frame(8'h00, 8'hFF, 1'b0, 0, 28);
        stream_check(8'h00, 8'hFF, 1'b0, 10);
        wait_and_finish(4);

        // Frame 3: in_valid toggling every other cycle
        load_frame(8'hE4, 8'h1B, 1'b1, 0, 28);
        stream_check(8'hE4, 8'h1B, 1'b0, -1);
        wait_and_finish(2);

        // Frame 4: reset at stream cycle 30
        load_frame(8'hE4, 8'h1B, 1'b0, 0, 28);
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        check("c30_valid", 32'(sw_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(sw_valid), 32'd0);
        check("async_rst_data", 32'({sw_data_ref, sw_data_query}), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_valid", 32'(sw_valid), 32'd0);

        // Reset mid-LOAD after 10 bytes: those bytes must be discarded
        load_frame(8'hFF, 8'hFF, 1'b0, 0, 10);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Fresh frame: 27 bytes then a pause must not start the stream
        load_frame(8'hE4, 8'h1B, 1'b0, 0, 27);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("partial_valid i=%0d", i), 32'(sw_valid), 32'd0);
            check($sformatf("partial_in_ready i=%0d", i), 32'(in_ready), 32'd1);
        end
        load_frame(8'hE4, 8'h1B, 1'b0, 27, 1);
        stream_check(8'hE4, 8'h1B, 1'b0, -1);
        wait_and_finish(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
